// File: rtl/port_arbiter_pkg.sv
// Shared definitions for the output-port arbiter: sizing defaults, FSM encodings and flit types.
// Also carries the router datapath widths so the crossbar and arbiter agree on them.
package port_arbiter_pkg;

  localparam int ARB_PORTS  = 5;
  localparam int ARB_STALLW = 8;
  localparam int ARB_SELW   = 3;
  localparam int DATAW      = 32;
  localparam int VCH        = 2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  typedef enum logic [1:0] {
    TYPE_HEAD = 2'd0,
    TYPE_BODY = 2'd1,
    TYPE_TAIL = 2'd2,
    TYPE_HT   = 2'd3
  } flit_type_e;

  typedef struct packed {
    flit_type_e       ftype;
    logic [VCH-1:0]   vc;
    logic [DATAW-1:0] data;
  } flit_t;

  function automatic logic is_tail(input flit_type_e t);
    return (t == TYPE_TAIL) || (t == TYPE_HT);
  endfunction

endpackage

// File: rtl/port_arbiter_if.sv
// Requester/downstream handshake bundle for one output-port arbiter.
// master = requester/downstream side, slave = the arbiter itself.
interface port_arbiter_if #(
  parameter int PORTS  = port_arbiter_pkg::ARB_PORTS,
  parameter int STALLW = port_arbiter_pkg::ARB_STALLW
);
  import port_arbiter_pkg::*;

  logic [PORTS-1:0]    req;
  logic [PORTS-1:0]    tail;
  logic                ordy;
  logic [PORTS-1:0]    grant;
  logic [ARB_SELW-1:0] sel;
  logic                busy;
  logic                xfer;
  logic [STALLW-1:0]   stall_cnt;

  modport master (
    output req, tail, ordy,
    input  grant, sel, busy, xfer, stall_cnt
  );

  modport slave (
    input  req, tail, ordy,
    output grant, sel, busy, xfer, stall_cnt
  );

endinterface

// File: rtl/port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit searching upward from ptr+1 with wrap.
// Zero latency; any=0 with all-zero outputs when nothing is requesting.
module rr_pick
  import port_arbiter_pkg::*;
#(
  parameter int PORTS = ARB_PORTS
) (
  input  logic [PORTS-1:0]    req,
  input  logic [ARB_SELW-1:0] ptr,
  output logic [PORTS-1:0]    onehot,
  output logic [ARB_SELW-1:0] idx,
  output logic                any
);

  logic [ARB_SELW-1:0] cand;

  // ptr itself is visited last, so a lone requester at ptr is still served
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = '0;
    for (int i = 1; i <= PORTS; i++) begin
      cand = ARB_SELW'((int'(ptr) + i) % PORTS);
      if (!any && req[cand]) begin
        any          = 1'b1;
        onehot[cand] = 1'b1;
        idx          = cand;
      end
    end
  end

endmodule

// File: rtl/port_arbiter.sv
// Packet-locking round-robin arbiter for one router output: grant one cycle after req, held until tail moves.
// Backpressure via ordy: a locked packet waits (stall_cnt counts, saturating) until downstream accepts.
module port_arbiter
  import port_arbiter_pkg::*;
#(
  parameter int PORTS  = ARB_PORTS,
  parameter int STALLW = ARB_STALLW
) (
  input logic          clk,
  input logic          rst_,
  port_arbiter_if.slave bus
);

  logic [0:0]          state_q, state_d;
  logic [PORTS-1:0]    grant_q, grant_d;
  logic [ARB_SELW-1:0] sel_q,   sel_d;
  logic [ARB_SELW-1:0] ptr_q,   ptr_d;
  logic [STALLW-1:0]   stall_q, stall_d;

  logic                busy;
  logic                xfer;
  logic [PORTS-1:0]    pick_oh;
  logic [ARB_SELW-1:0] pick_idx;
  logic                pick_any;

  rr_pick #(.PORTS(PORTS)) u_pick (
    .req    (bus.req),
    .ptr    (ptr_q),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // busy comes straight from the state flop, so reset kills xfer asynchronously too
  assign busy = (state_q == ST_LOCK);
  assign xfer = busy & bus.req[sel_q] & bus.ordy;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    stall_d = stall_q;
    if (state_q == ST_IDLE) begin
      stall_d = '0;
      if (pick_any) begin
        state_d = ST_LOCK;
        grant_d = pick_oh;
        sel_d   = pick_idx;
      end
    end else begin
      if (xfer) begin
        stall_d = '0;
        if (bus.tail[sel_q]) begin
          state_d = ST_IDLE;
          ptr_d   = sel_q;
          grant_d = '0;
          sel_d   = '0;
        end
      end else if (!(&stall_q)) begin
        stall_d = stall_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      ptr_q   <= ARB_SELW'(PORTS - 1);
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      stall_q <= stall_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.sel       = sel_q;
  assign bus.busy      = busy;
  assign bus.xfer      = xfer;
  assign bus.stall_cnt = stall_q;

endmodule

// File: doc/port_arbiter.md
PORT_ARBITER -- requirements
Module: port_arbiter

Interface
REQ-001 Parameter PORTS, 5, number of requesters (router input ports 0..4) sharing one output port.
REQ-002 Parameter STALLW, 8, width of the stall counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_  input  1  reset, asynchronous, active-low.
REQ-005 req  input  PORTS  bit i high: requester i holds a flit (head or body) for this output.
REQ-006 tail  input  PORTS  bit i high: requester i's current flit is a tail flit (TYPE_TAIL).
REQ-007 ordy  input  1  downstream can accept one flit this cycle (VC ready/ack).
REQ-008 grant  output  PORTS  one-hot registered grant; all-zero when idle.
REQ-009 sel  output  3  binary index of granted requester; 0 when idle.
REQ-010 busy  output  1  registered; high while a packet holds the output.
REQ-011 xfer  output  1  combinational; busy & req[sel] & ordy, one flit moves this cycle.
REQ-012 stall_cnt  output  STALLW  cycles the locked packet has waited with no transfer, saturating.

Function
REQ-013 The block SHALL implement two states: IDLE (busy=0) and LOCK (busy=1).
REQ-014 In IDLE with req nonzero, the block SHALL select the first set bit searching from (ptr+1) mod PORTS upward with wrap, and enter LOCK next edge with grant/sel set to that requester.
REQ-015 Grant latency SHALL be exactly one cycle: req sampled at edge N gives grant valid after edge N.
REQ-016 In IDLE with req all-zero, the block SHALL remain in IDLE with grant=0, sel=0.
REQ-017 In LOCK, grant and sel SHALL remain constant until a tail transfer (xfer & tail[sel]).
REQ-018 In LOCK, req bits of non-granted requesters SHALL be ignored.
REQ-019 In LOCK, req[sel] deasserting without a tail SHALL NOT release the lock (upstream bubble).
REQ-020 On a tail transfer the block SHALL return to IDLE next edge, set ptr to sel, and clear grant; one idle cycle precedes the next grant.
REQ-021 A single-flit packet (head is tail) SHALL be handled identically: release after its one transfer.
REQ-022 tail bits SHALL be ignored when xfer is low.
REQ-023 stall_cnt SHALL clear on entry to LOCK, on every xfer, and in IDLE; it SHALL increment each LOCK cycle with xfer low, saturating at 2^STALLW-1.
REQ-024 ptr SHALL wrap from PORTS-1 to 0; with only the ptr requester active it SHALL still be granted.

Reset
REQ-025 On rst_ low, asynchronously: state=IDLE, grant=0, sel=0, busy=0, stall_cnt=0, ptr=PORTS-1 (requester 0 has first priority).
REQ-026 Reset asserted mid-packet SHALL drop the lock immediately; after release, arbitration restarts from reset priority.
REQ-027 xfer SHALL be low while rst_ is low.

Structure
REQ-028 PORTS, STALLW, state encodings (IDLE, LOCK), and flit-type codes shall reside in the shared define header alongside DATAW/VCH definitions.
REQ-029 The round-robin priority picker shall be one sub-module, rr_pick (inputs req, ptr; output one-hot and index), purely combinational.
REQ-030 The router instantiates one port_arbiter per output port; the crossbar mux uses sel.

Verification
REQ-031 After reset, req=5'b00001 for one cycle -> grant=5'b00001, sel=0, busy=1 next cycle.
REQ-032 req=5'b11111 held, each packet 4 flits + tail, ordy=1 -> grants in order 0,1,2,3,4,0, one idle cycle between packets.
REQ-033 Port 2 locked, req=5'b00110, ordy=0 for 10 cycles -> grant stays 5'b00100, stall_cnt counts 1..10, xfer=0; ordy=1 -> stall_cnt=0.
REQ-034 ordy=0 held 300 cycles in LOCK -> stall_cnt saturates at 255, no wrap.
REQ-035 Port 3 locked, rst_ pulsed low mid-packet -> grant=0 and busy=0 immediately; next req=5'b01001 grants port 0.
REQ-036 Port 4 granted, single-flit packet with tail=5'b10000, ordy=1 -> release after one xfer; next req=5'b10001 grants port 0 (wrap).
